// File: rtl/pipo_register.sv
// Parallel-in/parallel-out holding register with load enable and async active-low reset.
// Define PIPO_REG_PARITY_EN to add a registered even-parity output (parity_out).
module pipo_register #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RST_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
`ifdef PIPO_REG_PARITY_EN
  output logic             parity_out,
`endif
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_data <= RST_VALUE;
    else if (load) r_data <= data_in;
  end

  assign data_out = r_data;

`ifdef PIPO_REG_PARITY_EN
  // Parity is registered alongside the word so both change on the same edge.
  logic r_parity;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_parity <= ^RST_VALUE;
    else if (load) r_parity <= ^data_in;
  end

  assign parity_out = r_parity;
`endif

endmodule

// File: tb/tb_pipo_register.sv
// Directed bench for pipo_register: per-cycle model compare plus literal spot checks.
module tb_pipo_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
`ifdef PIPO_REG_PARITY_EN
  logic         parity_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q;   // word the register must be holding
  bit running = 1'b0;

  pipo_register #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .data_in  (data_in),
`ifdef PIPO_REG_PARITY_EN
    .parity_out(parity_out),
`endif
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then settle 2 ns past it.
  task automatic step(input logic l, input logic [W-1:0] d);
    load    = l;
    data_in = d;
    @(posedge clk);
    if (reset && l) exp_q = d;
    #2;
  endtask

  // Model compare away from the active edge, every cycle.
  always @(negedge clk) begin
    if (running) begin
      chk("cycle_data", data_out, exp_q);
`ifdef PIPO_REG_PARITY_EN
      chk("cycle_parity", {{(W-1){1'b0}}, parity_out}, {{(W-1){1'b0}}, ^exp_q});
`endif
    end
  end

  initial begin
    reset = 1'b0; load = 1'b0; data_in = '0; exp_q = '0;
    #1 running = 1'b1;

    // 1. held in reset
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    chk("reset_hold", data_out, 8'h00);
    reset = 1'b1;

    // 2. single load then hold
    step(1'b1, 8'hAA);
    chk("load_AA", data_out, 8'hAA);
    step(1'b0, 8'hAA);
    step(1'b0, 8'hAA);
    chk("hold_AA", data_out, 8'hAA);

    // 3. reload
    step(1'b1, 8'h55);
    chk("load_55", data_out, 8'h55);

    // 4. data_in ignored while load low
    repeat (5) step(1'b0, 8'hFF);
    chk("hold_55", data_out, 8'h55);

    // 5. reset between edges wins immediately
    #1 reset = 1'b0; exp_q = '0;
    #1 chk("async_reset", data_out, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'hFF);
    chk("reset_over_load", data_out, 8'h00);
    #1 reset = 1'b1;
    #1 chk("after_release", data_out, 8'h00);
    step(1'b1, 8'hFF);
    chk("first_capture", data_out, 8'hFF);

    // continuous load behaves as a D register
    step(1'b1, 8'h3C);
    chk("track_3C", data_out, 8'h3C);
    step(1'b1, 8'hC3);
    step(1'b0, 8'h00);
    chk("track_C3", data_out, 8'hC3);
    step(1'b1, 8'h01);
    chk("load_01", data_out, 8'h01);

    // 6. parity
    step(1'b1, 8'h07);
`ifdef PIPO_REG_PARITY_EN
    chk("parity_07", {7'b0, parity_out}, 8'h01);
`endif
    chk("load_07", data_out, 8'h07);
    step(1'b1, 8'h03);
`ifdef PIPO_REG_PARITY_EN
    chk("parity_03", {7'b0, parity_out}, 8'h00);
`endif
    step(1'b1, 8'h80);
    #1 reset = 1'b0; exp_q = '0;
    #1 chk("reset_again", data_out, 8'h00);
`ifdef PIPO_REG_PARITY_EN
    chk("parity_reset", {7'b0, parity_out}, 8'h00);
`endif
    step(1'b0, 8'h00);
    #1 reset = 1'b1;
    step(1'b0, 8'h5A);
    chk("hold_after_reset", data_out, 8'h00);

    running = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
